freq_gate_controller: RTL and testbench

Measurement sequencer for the single-digit seven-segment frequency counter. It synchronises the external `sig` input and counts its rising edges during a fixed gate window. The result is latched as saturating two-digit BCD. The block then schedules the shared seven-segment digit output: tens digit, gap, ones digit, gap. After that it starts the next gate, or re-displays the same result while `hold` is high. It sits between the top-level io_in pins and the 7-segment decoder.

---
 rtl/freq_gate_controller.sv | 202 ++++++++++++++++++++
 tb/tb_freq_gate_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_controller.sv
// freq_gate_controller
//   Measurement sequencer for a single-digit seven-segment frequency counter.
//   Synchronises `sig`, counts its rising edges over a GATE_CYCLES window into
//   a saturating two-digit BCD value, latches the result, then multiplexes the
//   shared digit output: tens, gap, ones, gap. It then starts a new gate, or
//   repeats the display while `hold` is high at the end of the ones gap.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   sig        asynchronous input whose rising edges are counted
//   hold       sampled on the last GAP_O cycle: 1 = redisplay, 0 = measure again
//   digit      BCD digit (0-9) for the 7-segment decoder
//   blank      1 = decoder drives all segments off
//   is_tens    1 while the tens digit is presented (decimal point)
//   gate       1 during the gate window
//   meas_done  one-cycle pulse in the cycle a result is latched
//   overflow   latched result saturated (more than 99 edges)
module freq_gate_controller #(
    parameter int unsigned GATE_CYCLES  = 1000,
    parameter int unsigned DIGIT_CYCLES = 500,
    parameter int unsigned GAP_CYCLES   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig,
    input  logic       hold,
    output logic [3:0] digit,
    output logic       blank,
    output logic       is_tens,
    output logic       gate,
    output logic       meas_done,
    output logic       overflow
);

    localparam int unsigned MAX_A = (GATE_CYCLES > DIGIT_CYCLES) ? GATE_CYCLES : DIGIT_CYCLES;
    localparam int unsigned MAX_P = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int unsigned CW    = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    // The shared counter is loaded with (length - 1) on state entry and the
    // state ends on the cycle it reads zero.
    localparam logic [CW-1:0] GATE_LOAD  = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] DIGIT_LOAD = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        LATCH,
        SHOW_TENS,
        GAP_T,
        SHOW_ONES,
        GAP_O
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          p_q, p_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    disp_tens_q, disp_tens_d;
    logic [3:0]    disp_ones_q, disp_ones_d;
    logic          overflow_q, overflow_d;

    logic edge_det;
    logic cnt_last;

    always_comb begin
        s1_d        = sig;
        s2_d        = s1_q;
        p_d         = s2_q;
        edge_det    = s2_q & ~p_q;
        cnt_last    = (cnt_q == '0);

        state_d     = state_q;
        cnt_d       = cnt_q - CW'(1);
        tens_d      = tens_q;
        ones_d      = ones_q;
        ovf_d       = ovf_q;
        disp_tens_d = disp_tens_q;
        disp_ones_d = disp_ones_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            IDLE: begin
                tens_d  = '0;
                ones_d  = '0;
                ovf_d   = 1'b0;
                cnt_d   = GATE_LOAD;
                state_d = GATE;
            end
            GATE: begin
                if (edge_det) begin
                    // Saturate at 99 and remember that edges were lost.
                    if (tens_q == 4'd9 && ones_q == 4'd9) begin
                        ovf_d = 1'b1;
                    end else if (ones_q == 4'd9) begin
                        ones_d = '0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                disp_tens_d = tens_q;
                disp_ones_d = ones_q;
                overflow_d  = ovf_q;
                tens_d      = '0;
                ones_d      = '0;
                ovf_d       = 1'b0;
                cnt_d       = DIGIT_LOAD;
                state_d     = SHOW_TENS;
            end
            SHOW_TENS: begin
                if (cnt_last) begin
                    cnt_d   = GAP_LOAD;
                    state_d = GAP_T;
                end
            end
            GAP_T: begin
                if (cnt_last) begin
                    cnt_d   = DIGIT_LOAD;
                    state_d = SHOW_ONES;
                end
            end
            SHOW_ONES: begin
                if (cnt_last) begin
                    cnt_d   = GAP_LOAD;
                    state_d = GAP_O;
                end
            end
            GAP_O: begin
                if (cnt_last) begin
                    if (hold) begin
                        cnt_d   = DIGIT_LOAD;
                        state_d = SHOW_TENS;
                    end else begin
                        cnt_d   = GATE_LOAD;
                        state_d = GATE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode. digit follows the last digit shown: tens through
    // SHOW_TENS/GAP_T, ones everywhere else, so it never moves while blanked.
    always_comb begin
        gate      = (state_q == GATE);
        meas_done = (state_q == LATCH);
        is_tens   = (state_q == SHOW_TENS);
        overflow  = overflow_q;
        digit     = (state_q == SHOW_TENS || state_q == GAP_T) ? disp_tens_q : disp_ones_q;
        blank     = 1'b1;
        if (state_q == SHOW_TENS) begin
            blank = (disp_tens_q == 4'd0) && !overflow_q;
        end else if (state_q == SHOW_ONES) begin
            blank = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            p_q         <= 1'b0;
            tens_q      <= '0;
            ones_q      <= '0;
            ovf_q       <= 1'b0;
            disp_tens_q <= '0;
            disp_ones_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            p_q         <= p_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            ovf_q       <= ovf_d;
            disp_tens_q <= disp_tens_d;
            disp_ones_q <= disp_ones_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_freq_gate_controller.sv
// tb_freq_gate_controller
//   Randomised bench for freq_gate_controller with a schedule/count model:
//   the model tracks the position within a measurement round as an integer,
//   counts detected edges as a plain integer and saturates only when latching.
module tb_freq_gate_controller;

    localparam int G = 300;
    localparam int D = 4;
    localparam int P = 2;
    localparam int L = 2 * D + 2 * P;
    localparam int ROUND = G + 1 + L;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig;
    logic       hold;
    logic [3:0] digit;
    logic       blank;
    logic       is_tens;
    logic       gate;
    logic       meas_done;
    logic       overflow;

    freq_gate_controller #(
        .GATE_CYCLES (G),
        .DIGIT_CYCLES(D),
        .GAP_CYCLES  (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig      (sig),
        .hold     (hold),
        .digit    (digit),
        .blank    (blank),
        .is_tens  (is_tens),
        .gate     (gate),
        .meas_done(meas_done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Model state
    bit m_idle = 1'b1;
    bit m_meas = 1'b0;
    int m_pos  = 0;
    int m_cnt  = 0;
    int m_res  = 0;
    bit m_ovf  = 1'b0;
    bit h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;   // sig as sampled at the last three edges

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_miss++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp_v);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit hd);
        int d;
        if (r) begin
            m_idle = 1'b1; m_meas = 1'b0; m_pos = 0; m_cnt = 0;
            m_res = 0; m_ovf = 1'b0; h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
            return;
        end
        if (!m_idle && m_meas && m_pos < G && h1 && !h2) m_cnt++;
        if (m_idle) begin
            m_idle = 1'b0; m_meas = 1'b1; m_pos = 0; m_cnt = 0;
        end else begin
            if (m_meas && m_pos == G) begin
                m_res = (m_cnt > 99) ? 99 : m_cnt;
                m_ovf = (m_cnt > 99);
                m_cnt = 0;
            end
            d = m_meas ? m_pos - (G + 1) : m_pos;
            if (d == L - 1) begin
                m_meas = !hd;
                m_pos  = 0;
            end else begin
                m_pos++;
            end
        end
        h2 = h1; h1 = h0; h0 = s;
    endtask

    task automatic compare_all();
        int d, e_dig, e_blank, e_tens, e_gate, e_md;
        e_dig = m_res % 10; e_blank = 1; e_tens = 0; e_gate = 0; e_md = 0;
        if (!m_idle) begin
            d      = m_meas ? m_pos - (G + 1) : m_pos;
            e_gate = (m_meas && m_pos < G) ? 1 : 0;
            e_md   = (m_meas && m_pos == G) ? 1 : 0;
            if (d >= 0 && d < D) begin
                e_tens  = 1;
                e_dig   = m_res / 10;
                e_blank = (m_res / 10 == 0 && !m_ovf) ? 1 : 0;
            end else if (d >= D && d < D + P) begin
                e_dig = m_res / 10;
            end else if (d >= D + P && d < 2 * D + P) begin
                e_blank = 0;
            end
        end
        chk("digit", int'(digit), e_dig);
        chk("blank", int'(blank), e_blank);
        chk("is_tens", int'(is_tens), e_tens);
        chk("gate", int'(gate), e_gate);
        chk("meas_done", int'(meas_done), e_md);
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    // Drive inputs at the falling edge, advance the model across the rising
    // edge, then check at the next falling edge.
    task automatic step(input bit r, input bit s, input bit hd);
        rst = r; sig = s; hold = hd;
        model_step(r, s, hd);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic pin_reset_outputs();
        chk("rst_digit", int'(digit), 0);
        chk("rst_blank", int'(blank), 1);
        chk("rst_is_tens", int'(is_tens), 0);
        chk("rst_gate", int'(gate), 0);
        chk("rst_meas_done", int'(meas_done), 0);
        chk("rst_overflow", int'(overflow), 0);
    endtask

    // One full measurement round, entered on the first GATE cycle.
    // density < 0: n_pulses one-cycle pulses from gate position 4 plus an
    // optional pulse at extra_at; otherwise sig is random with that % density.
    task automatic run_round(input int n_pulses, input int extra_at, input int density,
                             input bit hold_val, input int exp_r, input bit exp_ovf,
                             input int abort_at);
        bit r, s, h;
        for (int k = 0; k < ROUND; k++) begin
            r = (k == abort_at);
            h = (k == ROUND - 1) ? hold_val : 1'($urandom_range(0, 1));
            if (k < G) begin
                if (density >= 0) s = ($urandom_range(0, 99) < density);
                else s = (k >= 4 && k < 4 + 2 * n_pulses && ((k - 4) % 2 == 0)) || (k == extra_at);
            end else begin
                s = (k >= ROUND - 2) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            step(r, s, h);
            if (r) begin
                pin_reset_outputs();
                return;
            end
            if (exp_r >= 0) begin
                if (k == G - 1) begin
                    chk("pin_meas_done", int'(meas_done), 1);
                    chk("pin_latch_gate", int'(gate), 0);
                end
                if (k == G) begin
                    chk("pin_tens_is_tens", int'(is_tens), 1);
                    chk("pin_overflow", int'(overflow), int'(exp_ovf));
                    chk("pin_tens_blank", int'(blank), (exp_r / 10 == 0 && !exp_ovf) ? 1 : 0);
                    if (exp_r / 10 != 0) chk("pin_tens_digit", int'(digit), exp_r / 10);
                end
                if (k == G + D + P) begin
                    chk("pin_ones_digit", int'(digit), exp_r % 10);
                    chk("pin_ones_blank", int'(blank), 0);
                    chk("pin_ones_is_tens", int'(is_tens), 0);
                end
            end
        end
        if (!hold_val) chk("pin_regate", int'(gate), 1);
    endtask

    // One display-only round, entered on the first SHOW_TENS cycle after hold.
    task automatic display_round(input bit hold_val, input int exp_r);
        bit s, h;
        if (exp_r >= 0) begin
            chk("pin_hold_is_tens", int'(is_tens), 1);
            chk("pin_hold_tens", int'(digit), exp_r / 10);
        end
        for (int k = 0; k < L; k++) begin
            h = (k == L - 1) ? hold_val : 1'($urandom_range(0, 1));
            s = (k >= L - 2) ? 1'b0 : 1'($urandom_range(0, 1));
            step(1'b0, s, h);
            if (exp_r >= 0) begin
                chk("pin_hold_gate", int'(gate), (k == L - 1 && !hold_val) ? 1 : 0);
                chk("pin_hold_meas_done", int'(meas_done), 0);
                if (k == D + P - 1) chk("pin_hold_ones", int'(digit), exp_r % 10);
            end
        end
    endtask

    initial begin
        bit hv;
        int ab;
        rst = 1'b1; sig = 1'b0; hold = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        pin_reset_outputs();
        cyc = 0;
        step(1'b0, 1'b0, 1'b0);
        chk("pin_first_gate", int'(gate), 1);

        run_round(0, -1, -1, 1'b0, 0, 1'b0, -1);
        chk("pin_cycle_314", cyc, 314);
        run_round(7, -1, -1, 1'b0, 7, 1'b0, -1);
        run_round(42, -1, -1, 1'b1, 42, 1'b0, -1);
        display_round(1'b1, 42);
        display_round(1'b0, 42);
        run_round(148, -1, -1, 1'b0, 99, 1'b1, -1);
        run_round(5, -1, -1, 1'b0, 5, 1'b0, -1);
        run_round(5, G - 3, -1, 1'b0, 6, 1'b0, -1);
        run_round(5, G - 2, -1, 1'b0, 5, 1'b0, -1);
        run_round(0, -1, -1, 1'b0, 0, 1'b0, -1);

        run_round(10, -1, -1, 1'b0, 10, 1'b0, G + 1 + D + P + 1);
        step(1'b0, 1'b0, 1'b0);
        run_round(3, -1, -1, 1'b0, 3, 1'b0, -1);
        run_round(30, -1, -1, 1'b0, 30, 1'b0, 46);
        step(1'b0, 1'b0, 1'b0);
        run_round(9, -1, -1, 1'b0, 9, 1'b0, -1);

        for (int i = 0; i < 14; i++) begin
            hv = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ROUND - 2)) : -1;
            run_round(0, -1, int'($urandom_range(0, 100)), hv, -1, 1'b0, ab);
            if (ab >= 0) step(1'b0, 1'b0, 1'b0);
            else if (hv) display_round(1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
